// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between execute-unit requesters, the issue stage and the register file write port.
// Latency: none (wires only); the arbiter registers the register-file side.
// Backpressure: per-requester valid/ready; issue side is stalled through issue_stall.
//
// Ports (signals):
//   req_valid/req_ready  per-requester handshake
//   req_rd/req_data      flattened per-requester destination and result
//   issue_valid/issue_rd issue-stage destination claim; issue_stall hazard back to issue
//   busy                 pending-write scoreboard
//   write/reg_wr/data_in register file write port
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ       = 3,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32
);
    localparam int AW = $clog2(NUM_REGISTERS);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*AW-1:0]         req_rd;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          issue_valid;
    logic [AW-1:0]                 issue_rd;
    logic                          issue_stall;
    logic [NUM_REGISTERS-1:0]      busy;
    logic                          write;
    logic [AW-1:0]                 reg_wr;
    logic [DATA_WIDTH-1:0]         data_in;

    // master: requesters and issue stage (and the register file sink)
    modport master (
        output req_valid, req_rd, req_data, issue_valid, issue_rd,
        input  req_ready, issue_stall, busy, write, reg_wr, data_in
    );

    // slave: the arbiter itself
    modport slave (
        input  req_valid, req_rd, req_data, issue_valid, issue_rd,
        output req_ready, issue_stall, busy, write, reg_wr, data_in
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port, plus a pending-write scoreboard.
// Latency: handshake at edge N, write/reg_wr/data_in valid during cycle N+1.
// Backpressure: one req_ready per cycle (combinational on req_valid); issue_stall on busy destination.
//
// Ports: clk, rst (async active-low), bus (regfile_wb_arbiter_if.slave).
module regfile_wb_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(NUM_REGISTERS);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]            ptr;
    logic [PW-1:0]            ptr_nxt;
    logic [PW-1:0]            gnt;
    logic                     gnt_vld;
    logic [PW-1:0]            sel;
    int                       idx;
    logic [NUM_REQ-1:0]       rdy;
    logic [AW-1:0]            gnt_rd;
    logic [DATA_WIDTH-1:0]    gnt_data;
    logic [NUM_REGISTERS-1:0] busy_q;
    logic [NUM_REGISTERS-1:0] busy_nxt;
    logic                     stall;
    logic                     write_q;
    logic [AW-1:0]            reg_wr_q;
    logic [DATA_WIDTH-1:0]    data_q;

    // Scan ptr, ptr+1, ... (mod NUM_REQ); first valid requester wins.
    always_comb begin
        gnt     = ptr;
        gnt_vld = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = PW'(idx);
            if (!gnt_vld && bus.req_valid[sel]) begin
                gnt_vld = 1'b1;
                gnt     = sel;
            end
        end
    end

    always_comb begin
        rdy = '0;
        if (gnt_vld) rdy[gnt] = 1'b1;
    end

    assign gnt_rd   = bus.req_rd[int'(gnt)*AW +: AW];
    assign gnt_data = bus.req_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
    assign ptr_nxt  = (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;

    assign stall = bus.issue_valid && busy_q[bus.issue_rd];

    // Clear first, then set, so a same-cycle set on the same register wins.
    always_comb begin
        busy_nxt = busy_q;
        if (gnt_vld && gnt_rd != '0)
            busy_nxt[gnt_rd] = 1'b0;
        if (bus.issue_valid && !stall && bus.issue_rd != '0)
            busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            busy_q   <= '0;
            write_q  <= 1'b0;
            reg_wr_q <= '0;
            data_q   <= '0;
        end else begin
            busy_q <= busy_nxt;
            if (gnt_vld) begin
                ptr      <= ptr_nxt;
                // x0 results complete the handshake but never reach the register file.
                write_q  <= (gnt_rd != '0);
                reg_wr_q <= gnt_rd;
                data_q   <= gnt_data;
            end else begin
                write_q  <= 1'b0;
            end
        end
    end

    assign bus.req_ready   = rdy;
    assign bus.issue_stall = stall;
    assign bus.busy        = busy_q;
    assign bus.write       = write_q;
    assign bus.reg_wr      = reg_wr_q;
    assign bus.data_in     = data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: reference model plus write-stage scoreboard.
// Latency checked: one cycle from handshake to write/reg_wr/data_in.
// Backpressure checked: req_ready grant order and issue_stall against modelled busy bits.
module tb_regfile_wb_arbiter;
    localparam int NR = 3;
    localparam int DW = 32;
    localparam int NREG = 32;

    typedef struct packed {
        logic        write;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_REGISTERS(NREG)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_REGISTERS(NREG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errs;
    int          checks;
    wb_t         sb[$];
    int          m_ptr;
    logic [31:0] m_busy;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [2:0]  obs_rdy;
    logic        obs_stall;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check combinational outputs, model the edge,
    // then pop the scoreboard and check the write stage and busy after the edge.
    task automatic step(input logic [2:0] v,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                        input logic iv, input logic [4:0] ird);
        logic [4:0]  rds [3];
        logic [31:0] ds  [3];
        int          g;
        logic [2:0]  exp_rdy;
        logic        exp_stall;
        wb_t         e;
        rds = '{r0, r1, r2};
        ds  = '{d0, d1, d2};
        bus.req_valid   = v;
        bus.req_rd      = {r2, r1, r0};
        bus.req_data    = {d2, d1, d0};
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        #1;
        g = -1;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (g < 0 && v[i]) g = i;
        end
        exp_rdy   = (g < 0) ? 3'b000 : (3'b001 << g);
        exp_stall = iv && m_busy[ird];
        obs_rdy   = bus.req_ready;
        obs_stall = bus.issue_stall;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        chk("issue_stall", 64'(bus.issue_stall), 64'(exp_stall));
        if (g >= 0) begin
            m_ptr   = (g + 1) % NR;
            e.write = (rds[g] != 5'd0);
            e.rd    = rds[g];
            e.data  = ds[g];
            m_rd    = rds[g];
            m_data  = ds[g];
            if (rds[g] != 5'd0) m_busy[rds[g]] = 1'b0;
        end else begin
            e.write = 1'b0;
            e.rd    = m_rd;
            e.data  = m_data;
        end
        if (iv && !exp_stall && ird != 5'd0) m_busy[ird] = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("write", 64'(bus.write), 64'(e.write));
        chk("reg_wr", 64'(bus.reg_wr), 64'(e.rd));
        chk("data_in", 64'(bus.data_in), 64'(e.data));
        chk("busy", 64'(bus.busy), 64'(m_busy));
    endtask

    task automatic idle_inputs();
        bus.req_valid   = '0;
        bus.req_rd      = '0;
        bus.req_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    initial begin
        logic [2:0] rr_exp [6];
        logic [4:0] rr_rd  [6];
        errs   = 0;
        checks = 0;
        m_ptr  = 0;
        m_busy = '0;
        m_rd   = '0;
        m_data = '0;
        rst    = 1'b0;
        idle_inputs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write", 64'(bus.write), 64'd0);
        chk("rst_reg_wr", 64'(bus.reg_wr), 64'd0);
        chk("rst_data_in", 64'(bus.data_in), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_issue_stall", 64'(bus.issue_stall), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single requester 1, rd=5
        step(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0);
        chk("t1_ready", 64'(obs_rdy), 64'(3'b010));
        chk("t1_write", 64'(bus.write), 64'd1);
        chk("t1_reg_wr", 64'(bus.reg_wr), 64'd5);
        chk("t1_data", 64'(bus.data_in), 64'hDEADBEEF);

        // Requester 2 alone brings the pointer back to 0
        step(3'b100, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h3333, 1'b0, 5'd0);

        // Round-robin fairness
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rr_rd  = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
        for (int c = 0; c < 6; c++) begin
            step(3'b111, 5'd1, 5'd2, 5'd3, 32'h100 + 32'(c), 32'h200 + 32'(c), 32'h300 + 32'(c),
                 1'b0, 5'd0);
            chk("rr_grant", 64'(obs_rdy), 64'(rr_exp[c]));
            chk("rr_reg_wr", 64'(bus.reg_wr), 64'(rr_rd[c]));
        end

        // x0 result from requester 0: accepted, no write, pointer moves to 1
        step(3'b001, 5'd0, 5'd0, 5'd0, 32'h12345678, 32'h0, 32'h0, 1'b0, 5'd0);
        chk("x0_ready", 64'(obs_rdy), 64'(3'b001));
        chk("x0_write", 64'(bus.write), 64'd0);
        step(3'b111, 5'd4, 5'd6, 5'd8, 32'hA, 32'hB, 32'hC, 1'b0, 5'd0);
        chk("x0_ptr_after", 64'(obs_rdy), 64'(3'b010));

        // Scoreboard round trip on x7
        step(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7);
        chk("sb_set", 64'(bus.busy[7]), 64'd1);
        step(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7);
        chk("sb_stall", 64'(obs_stall), 64'd1);
        step(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77777777, 1'b1, 5'd7);
        chk("sb_clr", 64'(bus.busy[7]), 64'd0);
        chk("sb_clr_write", 64'(bus.write), 64'd1);
        step(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7);
        chk("sb_stall_drop", 64'(obs_stall), 64'd0);

        // Set/clear collision on x9
        step(3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 1'b1, 5'd9);
        chk("collide_busy9", 64'(bus.busy[9]), 64'd1);

        // Random traffic through the model
        for (int c = 0; c < 40; c++) begin
            step(3'($urandom_range(0, 7)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 $urandom, $urandom, $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        // Get pointer to 2 and a busy bit set, then reset mid-operation
        step(3'b010, 5'd0, 5'd4, 5'd0, 32'h0, 32'h4444, 32'h0, 1'b1, 5'd11);
        chk("mid_pre_write", 64'(bus.write), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_write", 64'(bus.write), 64'd0);
        chk("mid_busy", 64'(bus.busy), 64'd0);
        chk("mid_reg_wr", 64'(bus.reg_wr), 64'd0);
        m_ptr  = 0;
        m_busy = '0;
        m_rd   = '0;
        m_data = '0;
        sb.delete();
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 5'd0);
        chk("mid_ptr0", 64'(obs_rdy), 64'(3'b001));

        idle_inputs();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port among `NUM_REQ` writeback sources (ALU, load unit, mul/div) using round-robin arbitration with a valid/ready handshake per source. Each accepted result is registered and presented one cycle later on the register file's `write`/`reg_wr`/`data_in` inputs. The block also keeps a pending-write scoreboard (one busy bit per architectural register) so the issue stage can stall on RAW/WAW hazards. It sits between the execute units and the register file.

## Interface
- `NUM_REQ`, 3: number of writeback requesters, 2..8; index 0 = ALU, 1 = load unit, 2 = mul/div.
- `DATA_WIDTH`, 32: result width.
- `NUM_REGISTERS`, 32: architectural registers; `AW = $clog2(NUM_REGISTERS)`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `req_valid`  in  NUM_REQ  requester i holds a result.
- `req_ready`  out  NUM_REQ  grant; handshake on requester i when `req_valid[i] && req_ready[i]` at a rising edge.
- `req_rd`  in  NUM_REQ*AW  destination register; slice i = bits [i*AW +: AW].
- `req_data`  in  NUM_REQ*DATA_WIDTH  result; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- `issue_valid`  in  1  issue stage dispatches an instruction that writes `issue_rd`.
- `issue_rd`  in  AW  destination of the issuing instruction.
- `issue_stall`  out  1  `issue_valid && busy[issue_rd]`; combinational.
- `busy`  out  NUM_REGISTERS  pending-write scoreboard; bit 0 is always 0.
- `write`  out  1  to register file `write`; registered.
- `reg_wr`  out  AW  to register file `reg_wr`; registered.
- `data_in`  out  DATA_WIDTH  to register file `data_in`; registered.

## Operation
- **Arbiter.** Round-robin pointer `ptr` (0..NUM_REQ-1). The grant goes to the first i with `req_valid[i]`, scanning `ptr, ptr+1, …` mod NUM_REQ. At most one `req_ready` bit is high per cycle. `req_ready` is 0 for all requesters when none is valid. `req_ready` depends combinationally on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- **Pointer update.** On a handshake by requester g, `ptr <= (g+1) mod NUM_REQ`. With no handshake, `ptr` holds.
- **Write stage.** A handshake by g loads `write <= (req_rd_g != 0)`, `reg_wr <= req_rd_g`, `data_in <= req_data_g`. With no handshake, `write <= 0` and `reg_wr`/`data_in` hold.
- **x0.** A result for x0 is accepted (handshake completes and the pointer advances), but `write` stays 0.
- **Scoreboard set.** `issue_valid && !issue_stall && issue_rd != 0` sets `busy[issue_rd]` at the edge.
- **Scoreboard clear.** A handshake with `req_rd_g != 0` clears `busy[req_rd_g]` at the same edge. The following cycle `write=1`, and the register file's write bypass supplies the value to same-cycle readers.
- **Set/clear collision.** If the same register is set and cleared in one cycle, set wins and the bit stays 1.
- **Stalled issue.** An issue while `busy[issue_rd]=1` is stalled: no set occurs and the issuer holds.
- **Occupancy.** No buffering inside the block. The write stage holds exactly one result and is overwritten every cycle a handshake occurs, so writeback throughput is one per cycle.

## Timing
- **Reset values** (async assert while `rst=0`): `ptr=0`, `busy=0`, `write=0`, `reg_wr=0`, `data_in=0`. `req_ready` and `issue_stall` follow their combinational equations from the reset state. Reset release is synchronous to `clk` at the next edge.
- **Reset mid-operation.** An in-flight write-stage result is dropped (`write` goes 0 immediately). Requesters must re-present after reset.
- **Latency.** Handshake at edge N, then `write`/`reg_wr`/`data_in` are valid during cycle N+1 and committed to the register file at edge N+1.
- **Busy timing.** The busy set is visible the cycle after issue. The busy clear is visible the cycle after the handshake, which is the same cycle `write=1`.
- **Requester hold.** A requester not granted holds `req_valid` and its slices stable until its handshake.
- **Starvation bound.** A continuously valid requester is granted within NUM_REQ cycles.

## Test plan
- **Reset:** `rst=0` → all outputs 0 and `ptr=0`. Release, then only requester 1 valid with rd=5, data=0xDEADBEEF → `req_ready=3'b010` that cycle; next cycle `write=1`, `reg_wr=5`, `data_in=0xDEADBEEF`.
- **Round-robin fairness:** all three requesters valid every cycle for 6 cycles with rd=1/2/3 → grants 0,1,2,0,1,2; `write` high on each of cycles 2..7 with `reg_wr` sequence 1,2,3,1,2,3.
- **x0 result:** requester 0 valid with rd=0 → handshake completes and `ptr` becomes 1; next cycle `write=0`; `busy` unchanged.
- **Scoreboard round trip:** issue rd=7 → `busy[7]=1` next cycle. A second issue to rd=7 → `issue_stall=1`. Requester 2 then hands off rd=7 → `busy[7]=0` in the same cycle `write=1`, and `issue_stall` drops.
- **Set/clear collision:** in one cycle issue rd=9 while requester 0 hands off rd=9 → `busy[9]` remains 1.
- **Reset mid-operation:** handshake at edge N, then `rst=0` during cycle N+1 → `write` drops to 0 asynchronously, `busy=0`, `ptr=0`.
